// File: rtl/serial_subtractor_if.sv
//------------------------------------------------------------------------------
// serial_subtractor_if : start/done handshake bundle for serial_subtractor.
// ovf is present only when OVERFLOW_FLAG_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             Bout;
`ifdef OVERFLOW_FLAG_EN
   logic             ovf;
`endif

   modport master (
      output start, A, B, Bin,
      input  busy, done, diff, Bout
`ifdef OVERFLOW_FLAG_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, A, B, Bin,
      output busy, done, diff, Bout
`ifdef OVERFLOW_FLAG_EN
      , output ovf
`endif
   );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// serial_subtractor : bit-serial diff = A - B - Bin, LSB first, one bit/clock.
// Optional signed overflow flag enabled by defining OVERFLOW_FLAG_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  wire logic          clk,
   input  wire logic          rst,
   serial_subtractor_if.slave bus
);

   localparam int c_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-2:0] r_res_sr;
   logic             r_br;
   logic [c_CW-1:0]  r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
`ifdef OVERFLOW_FLAG_EN
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_ovf;
`endif

   logic             w_a;
   logic             w_b;
   logic             w_d;
   logic             w_br_nxt;
   logic [WIDTH-1:0] w_res_nxt;

   // Full-subtractor cell on the current LSBs; new bit enters the result at the MSB.
   assign w_a       = r_a_sr[0];
   assign w_b       = r_b_sr[0];
   assign w_d       = w_a ^ w_b ^ r_br;
   assign w_br_nxt  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
   assign w_res_nxt = {w_d, r_res_sr};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_res_sr <= '0;
         r_br     <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_ovf    <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_a_sr   <= bus.A;
                  r_b_sr   <= bus.B;
                  r_br     <= bus.Bin;
                  r_res_sr <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
`ifdef OVERFLOW_FLAG_EN
                  r_a_msb  <= bus.A[WIDTH-1];
                  r_b_msb  <= bus.B[WIDTH-1];
`endif
                  r_state  <= S_SHIFT;
               end else begin
                  r_state  <= S_IDLE;
               end
            end
            S_SHIFT: begin
               r_a_sr   <= r_a_sr >> 1;
               r_b_sr   <= r_b_sr >> 1;
               r_res_sr <= w_res_nxt[WIDTH-1:1];
               r_br     <= w_br_nxt;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == c_LAST) begin
                  r_diff  <= w_res_nxt;
                  r_bout  <= w_br_nxt;
`ifdef OVERFLOW_FLAG_EN
                  r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.diff = r_diff;
   assign bus.Bout = r_bout;
`ifdef OVERFLOW_FLAG_EN
   assign bus.ovf  = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//------------------------------------------------------------------------------
// tb_serial_subtractor : scoreboard bench for serial_subtractor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_serial_subtractor;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(W)) bus ();
   serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
      int           due;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   last_done = 0;
   int   prev_done = 0;
   logic prev_d = 1'b0;
   exp_t m_e;
   logic [W:0] m_s;

   always @(posedge clk) cyc++;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic bin, input int due);
      exp_t e;
      int   r;
      int   sr;
      r  = int'(a) - int'(b) - int'(bin);
      sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
      e.a    = a;
      e.b    = b;
      e.bin  = bin;
      e.diff = W'(r);
      e.bout = (r < 0);
      e.ovf  = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
      e.due  = due;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor: every done pulse must match the oldest accepted operation.
   always @(negedge clk) begin
      if (bus.done) begin
         done_cnt++;
         prev_done = last_done;
         last_done = cyc;
         chk("done_single_cycle", 32'(prev_d), 32'd0);
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            m_e = q.pop_front();
            chk("diff", 32'(bus.diff), 32'(m_e.diff));
            chk("bout", 32'(bus.Bout), 32'(m_e.bout));
            chk("latency", 32'(cyc), 32'(m_e.due));
`ifdef OVERFLOW_FLAG_EN
            chk("ovf", 32'(bus.ovf), 32'(m_e.ovf));
`endif
            // Re-adding B and Bin must restore A; the carry out equals the borrow.
            m_s = {1'b0, bus.diff} + {1'b0, m_e.b} + {{W{1'b0}}, m_e.bin};
            chk("ripple_sum", 32'(m_s[W-1:0]), 32'(m_e.a));
            chk("ripple_carry", 32'(m_s[W]), 32'(m_e.bout));
         end
      end
      prev_d = bus.done;
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      bus.A     = a;
      bus.B     = b;
      bus.Bin   = bin;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      q.push_back(model(a, b, bin, cyc + W));
      bus.start = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy && n < 64);
      #1;
      if (bus.busy) chk("ready_timeout", 32'd1, 32'd0);
   endtask

   int dc;

   initial begin
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.Bin   = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_diff", 32'(bus.diff), 32'd0);
      chk("rst_bout", 32'(bus.Bout), 32'd0);
`ifdef OVERFLOW_FLAG_EN
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif

      // start together with rst: rst wins
      bus.start = 1'b1;
      bus.A     = 8'd7;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      chk("rst_wins_busy", 32'(bus.busy), 32'd0);

      // directed vectors, issued back-to-back
      wait_ready(); issue(8'd100, 8'd58, 1'b0);
      wait_ready(); issue(8'd3,   8'd64, 1'b0);
      wait_ready(); issue(8'd99,  8'd50, 1'b1);
      wait_ready(); issue(8'd255, 8'd255, 1'b1);
      wait_ready(); issue(8'd0,   8'd0,  1'b0);
      wait_ready(); issue(8'h80,  8'h01, 1'b0);
      wait_ready(); issue(8'd5,   8'd3,  1'b0);
      wait_ready(); issue(8'h7F,  8'hFF, 1'b0);

      // start pulses and operand changes during SHIFT are ignored
      wait_ready();
      repeat (2) @(negedge clk);
      dc = done_cnt;
      issue(8'd100, 8'd58, 1'b0);
      @(negedge clk);
      @(negedge clk);
      bus.A     = 8'd1;
      bus.B     = 8'd2;
      bus.Bin   = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      wait_ready();
      repeat (W + 3) @(negedge clk);
      #1;
      chk("ignored_start_dones", 32'(done_cnt - dc), 32'd1);
      chk("ignored_start_queue", 32'(q.size()), 32'd0);

      // start in the DONE cycle: done pulses WIDTH+1 apart
      issue(8'd200, 8'd17, 1'b1);
      wait_ready();
      issue(8'd17, 8'd200, 1'b0);
      wait_ready();
      chk("b2b_spacing", 32'(last_done - prev_done), 32'(W + 1));

      // rst at cnt=4 aborts without a done pulse
      repeat (2) @(negedge clk);
      #1;
      issue(8'd50, 8'd20, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      dc = done_cnt;
      @(negedge clk);
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_diff", 32'(bus.diff), 32'd0);
      chk("abort_bout", 32'(bus.Bout), 32'd0);
      repeat (W + 3) @(negedge clk);
      #1;
      chk("abort_no_done", 32'(done_cnt - dc), 32'd0);

      // randomized operations with occasional idle gaps
      for (int i = 0; i < 1000; i++) begin
         wait_ready();
         if ($urandom_range(3) == 0) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #1;
         end
         issue(W'($urandom), W'($urandom), 1'($urandom));
      end

      wait_ready();
      repeat (W + 3) @(negedge clk);
      #1;
      chk("final_queue_empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
